rotary_ring_ctrl: RTL and testbench

ROTARY_RING_CTRL -- requirements
Module: rotary_ring_ctrl

---
 rtl/rotary_ring_ctrl.sv | 93 +++++++++
 tb/tb_rotary_ring_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotary_ring_ctrl.sv
// Rotary-encoder LED ring controller: position, inversion and bar/dot display
// with registered LED pattern, brightness byte and a coalescing frame request.
module rotary_ring_ctrl #(
  parameter int N_LEDS = 12,
  parameter bit WRAP   = 1'b1,
  parameter int POS_W  = $clog2(N_LEDS)
) (
  input  logic              clk,
  input  logic              res,
  input  logic              rot_up,
  input  logic              rot_dn,
  input  logic              push,
  input  logic              mode_in,
  input  logic [1:0]        intensity_in,
  input  logic              frame_ack,
  output logic [N_LEDS-1:0] led_mask,
  output logic [POS_W-1:0]  pos,
  output logic              inverted,
  output logic [7:0]        intensity_out,
  output logic              frame_req
);

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LEDS - 1);

  logic [POS_W-1:0]  pos_q, pos_d;
  logic              inv_q, inv_d;
  logic              mode_q;
  logic [N_LEDS-1:0] mask_q, mask_d;
  logic [7:0]        int_q, int_d;
  logic              req_q, req_d;
  logic              change;

  // Opposing pulses cancel; the ends either wrap or saturate.
  always_comb begin
    pos_d = pos_q;
    if (rot_up && !rot_dn) begin
      if (pos_q == POS_MAX) pos_d = WRAP ? '0 : POS_MAX;
      else                  pos_d = pos_q + 1'b1;
    end else if (rot_dn && !rot_up) begin
      if (pos_q == '0) pos_d = WRAP ? POS_MAX : '0;
      else             pos_d = pos_q - 1'b1;
    end
  end

  assign inv_d = inv_q ^ push;

  always_comb begin
    mask_d = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      mask_d[i] = (mode_q ? (i <= int'(pos_q)) : (i == int'(pos_q))) ^ inv_q;
    end
  end

  always_comb begin
    int_d = 8'h01;
    case (intensity_in)
      2'b00: int_d = 8'h01;
      2'b01: int_d = 8'h02;
      2'b10: int_d = 8'h08;
      2'b11: int_d = 8'h20;
      default: int_d = 8'h01;
    endcase
  end

  // A fresh change always wins over an acknowledge on the same edge.
  assign change = (mask_d != mask_q) || (int_d != int_q);
  assign req_d  = change || (req_q && !frame_ack);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      pos_q  <= '0;
      inv_q  <= 1'b0;
      mode_q <= 1'b0;
      mask_q <= N_LEDS'(1);
      int_q  <= 8'h01;
      req_q  <= 1'b1;
    end else begin
      pos_q  <= pos_d;
      inv_q  <= inv_d;
      mode_q <= mode_in;
      mask_q <= mask_d;
      int_q  <= int_d;
      req_q  <= req_d;
    end
  end

  assign led_mask      = mask_q;
  assign pos           = pos_q;
  assign inverted      = inv_q;
  assign intensity_out = int_q;
  assign frame_req     = req_q;

endmodule

// File: tb/tb_rotary_ring_ctrl.sv
// Bench for rotary_ring_ctrl: three instances (12 wrap, 12 saturate, 5 wrap)
// share one stimulus stream and are checked against an arithmetic model.
module tb_rotary_ring_ctrl;

  localparam int NOF [3] = '{12, 12, 5};
  localparam bit WOF [3] = '{1'b1, 1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       rotUp = 1'b0, rotDn = 1'b0, pushIn = 1'b0, modeIn = 1'b0, frameAck = 1'b0;
  logic [1:0] intensityIn = 2'b00;

  logic [11:0] mask0, mask1;
  logic [4:0]  mask2;
  logic [3:0]  pos0, pos1;
  logic [2:0]  pos2;
  logic        inv0, inv1, inv2, req0, req1, req2;
  logic [7:0]  int0, int1, int2;

  logic [31:0] obsMask [3];
  logic [31:0] obsPos  [3];
  logic        obsInv  [3];
  logic        obsReq  [3];
  logic [7:0]  obsInt  [3];

  int          mPos  [3];
  bit          mInv  [3];
  bit          mMode [3];
  logic [31:0] mMask [3];
  logic [7:0]  mInt  [3];
  bit          mReq  [3];

  int nChecks = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  rotary_ring_ctrl #(.N_LEDS(12), .WRAP(1'b1)) dutWrap (
    .clk(clk), .res(res), .rot_up(rotUp), .rot_dn(rotDn), .push(pushIn),
    .mode_in(modeIn), .intensity_in(intensityIn), .frame_ack(frameAck),
    .led_mask(mask0), .pos(pos0), .inverted(inv0), .intensity_out(int0), .frame_req(req0));

  rotary_ring_ctrl #(.N_LEDS(12), .WRAP(1'b0)) dutSat (
    .clk(clk), .res(res), .rot_up(rotUp), .rot_dn(rotDn), .push(pushIn),
    .mode_in(modeIn), .intensity_in(intensityIn), .frame_ack(frameAck),
    .led_mask(mask1), .pos(pos1), .inverted(inv1), .intensity_out(int1), .frame_req(req1));

  rotary_ring_ctrl #(.N_LEDS(5), .WRAP(1'b1)) dutFive (
    .clk(clk), .res(res), .rot_up(rotUp), .rot_dn(rotDn), .push(pushIn),
    .mode_in(modeIn), .intensity_in(intensityIn), .frame_ack(frameAck),
    .led_mask(mask2), .pos(pos2), .inverted(inv2), .intensity_out(int2), .frame_req(req2));

  always_comb begin
    obsMask[0] = 32'(mask0); obsMask[1] = 32'(mask1); obsMask[2] = 32'(mask2);
    obsPos[0]  = 32'(pos0);  obsPos[1]  = 32'(pos1);  obsPos[2]  = 32'(pos2);
    obsInv[0]  = inv0;       obsInv[1]  = inv1;       obsInv[2]  = inv2;
    obsReq[0]  = req0;       obsReq[1]  = req1;       obsReq[2]  = req2;
    obsInt[0]  = int0;       obsInt[1]  = int1;       obsInt[2]  = int2;
  end

  // Pattern from plain arithmetic: dot = 2^p, bar = 2^(p+1)-1, inverted within n bits.
  function automatic logic [31:0] maskOf(int n, int p, bit inv, bit bar);
    logic [63:0] full, raw;
    full = (64'd1 << n) - 64'd1;
    raw  = bar ? ((64'd1 << (p + 1)) - 64'd1) : (64'd1 << p);
    if (inv) raw = ~raw & full;
    return raw[31:0];
  endfunction

  function automatic int movePos(int n, bit wrap, int p, bit up, bit dn);
    if (up && !dn) return wrap ? (p + 1) % n : ((p + 1 > n - 1) ? n - 1 : p + 1);
    if (dn && !up) return wrap ? (p + n - 1) % n : ((p == 0) ? 0 : p - 1);
    return p;
  endfunction

  function automatic logic [7:0] intMap(logic [1:0] sel);
    case (sel)
      2'b00: return 8'h01;
      2'b01: return 8'h02;
      2'b10: return 8'h08;
      default: return 8'h20;
    endcase
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 3; k++) begin
      mPos[k] = 0; mInv[k] = 1'b0; mMode[k] = 1'b0;
      mMask[k] = 32'd1; mInt[k] = 8'h01; mReq[k] = 1'b1;
    end
  endtask

  // One clock: advance the model with the inputs seen on the edge, then drop the pulses.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      logic [31:0] nm;
      logic [7:0]  ni;
      bit          ch;
      nm = maskOf(NOF[k], mPos[k], mInv[k], mMode[k]);
      ni = intMap(intensityIn);
      ch = (nm != mMask[k]) || (ni != mInt[k]);
      mReq[k]  = ch || (mReq[k] && !frameAck);
      mMask[k] = nm;
      mInt[k]  = ni;
      mPos[k]  = movePos(NOF[k], WOF[k], mPos[k], rotUp, rotDn);
      mInv[k]  = mInv[k] ^ pushIn;
      mMode[k] = modeIn;
    end
    @(negedge clk);
    rotUp = 1'b0; rotDn = 1'b0; pushIn = 1'b0; frameAck = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    #2;
    res = 1'b1;
    rotUp = 1'b0; rotDn = 1'b0; pushIn = 1'b0; frameAck = 1'b0;
    modeIn = 1'b0; intensityIn = 2'b00;
    @(negedge clk);
    res = 1'b0;
    modelReset();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      nChecks += 5;
      if (obsPos[k] !== 32'd0) begin nFail++; $display("[TB] FAIL reset_pos[%0d]: got %0h want 0", k, obsPos[k]); end
      if (obsMask[k] !== 32'd1) begin nFail++; $display("[TB] FAIL reset_mask[%0d]: got %0h want 1", k, obsMask[k]); end
      if (obsInv[k] !== 1'b0) begin nFail++; $display("[TB] FAIL reset_inv[%0d]: got %b want 0", k, obsInv[k]); end
      if (obsInt[k] !== 8'h01) begin nFail++; $display("[TB] FAIL reset_int[%0d]: got %0h want 01", k, obsInt[k]); end
      if (obsReq[k] !== 1'b1) begin nFail++; $display("[TB] FAIL reset_req[%0d]: got %b want 1", k, obsReq[k]); end
    end
    res = 1'b0;
    modelReset();
  endtask

  task automatic test_wrap_up();
    doReset();
    for (int i = 1; i <= 12; i++) begin
      rotUp = 1'b1;
      tick();
      nChecks++;
      if (pos0 !== 4'(i % 12)) begin nFail++; $display("[TB] FAIL wrap_pos step %0d: got %0d want %0d", i, pos0, i % 12); end
      tick();
      nChecks++;
      if (mask0 !== 12'(1 << (i % 12))) begin nFail++; $display("[TB] FAIL wrap_mask step %0d: got %0h want %0h", i, mask0, 12'(1 << (i % 12))); end
      for (int k = 0; k < 3; k++) begin
        nChecks += 3;
        if (obsPos[k] !== 32'(mPos[k])) begin nFail++; $display("[TB] FAIL wrap_model_pos[%0d]: got %0d want %0d", k, obsPos[k], mPos[k]); end
        if (obsMask[k] !== mMask[k]) begin nFail++; $display("[TB] FAIL wrap_model_mask[%0d]: got %0h want %0h", k, obsMask[k], mMask[k]); end
        if (obsReq[k] !== mReq[k]) begin nFail++; $display("[TB] FAIL wrap_model_req[%0d]: got %b want %b", k, obsReq[k], mReq[k]); end
      end
    end
  endtask

  task automatic test_saturate();
    doReset();
    frameAck = 1'b1;
    tick();
    rotDn = 1'b1;
    tick();
    tick();
    nChecks += 6;
    if (pos1 !== 4'd0) begin nFail++; $display("[TB] FAIL sat_dn_pos: got %0d want 0", pos1); end
    if (mask1 !== 12'h001) begin nFail++; $display("[TB] FAIL sat_dn_mask: got %0h want 001", mask1); end
    if (req1 !== 1'b0) begin nFail++; $display("[TB] FAIL sat_dn_req: got %b want 0", req1); end
    if (pos0 !== 4'd11) begin nFail++; $display("[TB] FAIL wrap_dn_pos: got %0d want 11", pos0); end
    if (pos2 !== 3'd4) begin nFail++; $display("[TB] FAIL five_dn_pos: got %0d want 4", pos2); end
    if (mask2 !== 5'h10) begin nFail++; $display("[TB] FAIL five_dn_mask: got %0h want 10", mask2); end
    for (int i = 0; i < 15; i++) begin
      rotUp = 1'b1;
      tick();
    end
    tick();
    tick();
    nChecks += 2;
    if (pos1 !== 4'd11) begin nFail++; $display("[TB] FAIL sat_up_pos: got %0d want 11", pos1); end
    if (mask1 !== 12'h800) begin nFail++; $display("[TB] FAIL sat_up_mask: got %0h want 800", mask1); end
  endtask

  task automatic test_bar_invert();
    doReset();
    modeIn = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      rotUp = 1'b1;
      tick();
    end
    tick();
    tick();
    nChecks++;
    if (mask0 !== 12'h00F) begin nFail++; $display("[TB] FAIL bar_mask: got %0h want 00f", mask0); end
    pushIn = 1'b1;
    tick();
    tick();
    nChecks += 2;
    if (mask0 !== 12'hFF0) begin nFail++; $display("[TB] FAIL bar_inv_mask: got %0h want ff0", mask0); end
    if (inv0 !== 1'b1) begin nFail++; $display("[TB] FAIL bar_inv_flag: got %b want 1", inv0); end
    frameAck = 1'b1;
    tick();
    rotUp = 1'b1; rotDn = 1'b1;
    tick();
    tick();
    nChecks += 3;
    if (mask0 !== 12'hFF0) begin nFail++; $display("[TB] FAIL both_mask: got %0h want ff0", mask0); end
    if (pos0 !== 4'd3) begin nFail++; $display("[TB] FAIL both_pos: got %0d want 3", pos0); end
    if (req0 !== 1'b0) begin nFail++; $display("[TB] FAIL both_req: got %b want 0", req0); end
    modeIn = 1'b0;
  endtask

  task automatic test_handshake();
    doReset();
    for (int i = 0; i < 3; i++) begin
      rotUp = 1'b1;
      tick();
    end
    tick();
    tick();
    nChecks += 2;
    if (req0 !== 1'b1) begin nFail++; $display("[TB] FAIL hs_coalesce_req: got %b want 1", req0); end
    if (mask0 !== 12'h008) begin nFail++; $display("[TB] FAIL hs_coalesce_mask: got %0h want 008", mask0); end
    rotUp = 1'b1;
    tick();
    frameAck = 1'b1;
    tick();
    nChecks += 2;
    if (req0 !== 1'b1) begin nFail++; $display("[TB] FAIL hs_ack_change_req: got %b want 1", req0); end
    if (mask0 !== 12'h010) begin nFail++; $display("[TB] FAIL hs_ack_change_mask: got %0h want 010", mask0); end
    frameAck = 1'b1;
    tick();
    nChecks++;
    if (req0 !== 1'b0) begin nFail++; $display("[TB] FAIL hs_ack_clear_req: got %b want 0", req0); end
  endtask

  task automatic test_intensity();
    logic [1:0] sel  [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    logic [7:0] want [4] = '{8'h02, 8'h08, 8'h20, 8'h01};
    doReset();
    frameAck = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      intensityIn = sel[i];
      tick();
      nChecks += 2;
      if (int0 !== want[i]) begin nFail++; $display("[TB] FAIL int_value sel %b: got %0h want %0h", sel[i], int0, want[i]); end
      if (req0 !== 1'b1) begin nFail++; $display("[TB] FAIL int_req sel %b: got %b want 1", sel[i], req0); end
      frameAck = 1'b1;
      tick();
    end
  endtask

  task automatic test_midreset();
    doReset();
    rotUp = 1'b1; tick();
    rotUp = 1'b1; pushIn = 1'b1; tick();
    tick();
    #2;
    res = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      nChecks += 4;
      if (obsPos[k] !== 32'd0) begin nFail++; $display("[TB] FAIL midres_pos[%0d]: got %0d want 0", k, obsPos[k]); end
      if (obsMask[k] !== 32'd1) begin nFail++; $display("[TB] FAIL midres_mask[%0d]: got %0h want 1", k, obsMask[k]); end
      if (obsReq[k] !== 1'b1) begin nFail++; $display("[TB] FAIL midres_req[%0d]: got %b want 1", k, obsReq[k]); end
      if (obsInv[k] !== 1'b0) begin nFail++; $display("[TB] FAIL midres_inv[%0d]: got %b want 0", k, obsInv[k]); end
    end
    @(negedge clk);
    res = 1'b0;
    modelReset();
    rotUp = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      nChecks += 3;
      if (obsPos[k] !== 32'd1) begin nFail++; $display("[TB] FAIL release_pos[%0d]: got %0d want 1", k, obsPos[k]); end
      if (obsMask[k] !== 32'd1) begin nFail++; $display("[TB] FAIL release_mask[%0d]: got %0h want 1", k, obsMask[k]); end
      if (obsReq[k] !== mReq[k]) begin nFail++; $display("[TB] FAIL release_req[%0d]: got %b want %b", k, obsReq[k], mReq[k]); end
    end
  endtask

  task automatic test_random();
    doReset();
    for (int c = 0; c < 400; c++) begin
      rotUp    = ($urandom_range(0, 2) == 0);
      rotDn    = ($urandom_range(0, 2) == 0);
      pushIn   = ($urandom_range(0, 7) == 0);
      frameAck = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) modeIn = ~modeIn;
      if ($urandom_range(0, 7) == 0) intensityIn = 2'($urandom_range(0, 3));
      tick();
      for (int k = 0; k < 3; k++) begin
        nChecks += 5;
        if (obsPos[k] !== 32'(mPos[k])) begin nFail++; $display("[TB] FAIL rnd_pos[%0d] cyc %0d: got %0d want %0d", k, c, obsPos[k], mPos[k]); end
        if (obsMask[k] !== mMask[k]) begin nFail++; $display("[TB] FAIL rnd_mask[%0d] cyc %0d: got %0h want %0h", k, c, obsMask[k], mMask[k]); end
        if (obsInv[k] !== mInv[k]) begin nFail++; $display("[TB] FAIL rnd_inv[%0d] cyc %0d: got %b want %b", k, c, obsInv[k], mInv[k]); end
        if (obsInt[k] !== mInt[k]) begin nFail++; $display("[TB] FAIL rnd_int[%0d] cyc %0d: got %0h want %0h", k, c, obsInt[k], mInt[k]); end
        if (obsReq[k] !== mReq[k]) begin nFail++; $display("[TB] FAIL rnd_req[%0d] cyc %0d: got %b want %b", k, c, obsReq[k], mReq[k]); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    test_reset();
    test_wrap_up();
    test_saturate();
    test_bar_invert();
    test_handshake();
    test_intensity();
    test_midreset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
